wb_sram_bridge: RTL and testbench

WB_SRAM_BRIDGE -- requirements
Module: wb_sram_bridge

---
 rtl/wb_sram_bridge.sv | 138 +++++++++++++
 tb/tb_wb_sram_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave to single-port SRAM (OpenRAM-style port 0) bridge.
// Optional macro WB_SRAM_ERR_EN: out-of-window requests get wb_err_o instead of aliasing.
module wb_sram_bridge #(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          ADDR_WIDTH = 8
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [3:0]            wb_sel_i,
   input  logic [31:0]           wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [3:0]            sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [31:0]           sram_din0,
   input  logic [31:0]           sram_dout0
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   // 33-bit end address so a window touching 2^32 cannot wrap.
   localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);

   state_t                state_q, state_d;
   logic                  csb_q, csb_d;
   logic                  web_q, web_d;
   logic [3:0]            wmask_q, wmask_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           din_q, din_d;
   logic [31:0]           dat_q, dat_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic                  in_range;
   logic                  accept;

   assign in_range = ({1'b0, wb_adr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, wb_adr_i} < WIN_END);

`ifdef WB_SRAM_ERR_EN
   assign accept = in_range;
`else
   logic unused_in_range;
   assign unused_in_range = in_range;
   assign accept          = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      csb_d   = 1'b1;
      web_d   = web_q;
      wmask_d = wmask_q;
      addr_d  = addr_q;
      din_d   = din_q;
      dat_d   = dat_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               if (accept) begin
                  csb_d   = 1'b0;
                  web_d   = !wb_we_i;
                  wmask_d = wb_sel_i;
                  addr_d  = wb_adr_i[ADDR_WIDTH+1:2];
                  din_d   = wb_dat_i;
                  state_d = ISSUE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ACK;
               end
            end
         end
         // The SRAM samples csb0 on the edge leaving ISSUE, so a dropped cycle
         // here still commits the access; only the acknowledge is withheld.
         ISSUE: begin
            if (!wb_cyc_i) begin
               state_d = IDLE;
            end else if (web_q) begin
               state_d = WAIT;
            end else begin
               ack_d   = 1'b1;
               state_d = ACK;
            end
         end
         WAIT: begin
            if (!wb_cyc_i) begin
               state_d = IDLE;
            end else begin
               dat_d   = sram_dout0;
               ack_d   = 1'b1;
               state_d = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         csb_q   <= 1'b1;
         web_q   <= 1'b1;
         wmask_q <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         csb_q   <= csb_d;
         web_q   <= web_d;
         wmask_q <= wmask_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign sram_csb0   = csb_q;
   assign sram_web0   = web_q;
   assign sram_wmask0 = wmask_q;
   assign sram_addr0  = addr_q;
   assign sram_din0   = din_q;
   assign wb_dat_o    = dat_q;
   assign wb_ack_o    = ack_q;
   assign wb_err_o    = err_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Bench for wb_sram_bridge: behavioural SRAM plus a word-array reference model,
// directed cases followed by random Wishbone transfers.
module tb_wb_sram_bridge;
   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int          AW    = 8;
   localparam int          WORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          cyc, stb, we;
   logic [3:0]    sel;
   logic [31:0]   adr, wdat;
   logic [31:0]   dat_o;
   logic          ack_o, err_o;
   logic          csb, web;
   logic [3:0]    wmask;
   logic [AW-1:0] saddr;
   logic [31:0]   sdin;
   logic [31:0]   sdout;

   always #5 clk = ~clk;

   wb_sram_bridge #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
      .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(dat_o),
      .wb_ack_o(ack_o), .wb_err_o(err_o),
      .sram_csb0(csb), .sram_web0(web), .sram_wmask0(wmask),
      .sram_addr0(saddr), .sram_din0(sdin), .sram_dout0(sdout)
   );

   // Synchronous SRAM: captures controls on the rising edge, read data valid the following cycle.
   logic [31:0] sram_mem [WORDS];
   logic [31:0] sram_w;
   always @(posedge clk) begin
      if (!csb) begin
         if (!web) begin
            sram_w = sram_mem[saddr];
            for (int b = 0; b < 4; b++)
               if (wmask[b]) sram_w[8*b +: 8] = sdin[8*b +: 8];
            sram_mem[saddr] <= sram_w;
         end else begin
            sdout <= sram_mem[saddr];
         end
      end
   end

   // Reference model state
   logic [31:0] ref_mem [WORDS];
   logic [31:0] ref_dat;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
      return (old & ~m) | (nw & m);
   endfunction

   // Observations of one transfer; latencies count edges from the request edge
   // to the edge at which the master samples the termination signal.
   int          ack_lat, err_lat, ack_cnt, err_cnt, csb_lo;
   logic        web_s;
   logic [7:0]  addr_s;
   logic [3:0]  mask_s;
   logic [31:0] din_s;

   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int drop_after);
      int term;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      @(posedge clk);
      ack_lat = -1; err_lat = -1; ack_cnt = 0; err_cnt = 0; csb_lo = 0; term = -1;
      web_s = 1'b0; addr_s = '0; mask_s = '0; din_s = '0;
      for (int k = 1; k <= 8; k++) begin
         #1;
         if (drop_after == k || (term >= 0 && term == k - 1)) begin
            cyc = 1'b0; stb = 1'b0;
         end
         if (!csb) begin
            csb_lo++; web_s = web; addr_s = saddr; mask_s = wmask; din_s = sdin;
         end
         if (ack_o) begin ack_cnt++; if (ack_lat < 0) ack_lat = k; end
         if (err_o) begin err_cnt++; if (err_lat < 0) err_lat = k; end
         if ((ack_o || err_o) && term < 0) term = k;
         @(posedge clk);
      end
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
      longint la;
      bit     accepted;
      int     word;
      la   = longint'(a);
      word = int'((a >> 2) % WORDS);
`ifdef WB_SRAM_ERR_EN
      accepted = (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * WORDS);
`else
      accepted = (la >= 0);
`endif
      xfer(w, a, d, s, 0);
      if (!accepted) begin
         check("err_lat", ack_lat == -1 ? err_lat : -2, 1);
         check("err_cnt", err_cnt, 1);
         check("err_ack_cnt", ack_cnt, 0);
         check("err_csb_lo", csb_lo, 0);
      end else begin
         check(w ? "wr_ack_lat" : "rd_ack_lat", ack_lat, w ? 2 : 3);
         check("ack_cnt", ack_cnt, 1);
         check("err_cnt", err_cnt, 0);
         check("csb_lo", csb_lo, 1);
         check("web", {31'b0, web_s}, {31'b0, ~w});
         check("addr", {24'b0, addr_s}, word);
         if (w) begin
            check("wmask", {28'b0, mask_s}, {28'b0, s});
            check("din", din_s, d);
            ref_mem[word] = merge(ref_mem[word], d, s);
         end else begin
            ref_dat = ref_mem[word];
         end
      end
      check("dat_o", dat_o, ref_dat);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_csb"},   {31'b0, csb},   1);
      check({pfx, "_web"},   {31'b0, web},   1);
      check({pfx, "_wmask"}, {28'b0, wmask}, 0);
      check({pfx, "_addr"},  {24'b0, saddr}, 0);
      check({pfx, "_din"},   sdin,           0);
      check({pfx, "_dat"},   dat_o,          0);
      check({pfx, "_ack"},   {31'b0, ack_o}, 0);
      check({pfx, "_err"},   {31'b0, err_o}, 0);
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      for (int i = 0; i < WORDS; i++) begin
         sram_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
         ref_mem[i]  = 32'h5A00_0000 ^ (i * 32'h0001_0203);
      end
      ref_dat = '0;
      rst = 1'b0;

      run(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
      run(1'b0, BASE + 32'h10, 32'h0, 4'hF);
      check("rd_deadbeef", dat_o, 32'hDEADBEEF);
      run(1'b1, BASE + 32'h10, 32'h11223344, 4'b0101);
      run(1'b0, BASE + 32'h10, 32'h0, 4'hF);
      check("rd_merged", dat_o, 32'hDE22BE44);
      run(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000);
      run(1'b0, BASE + 32'h10, 32'h0, 4'hF);
      check("rd_sel0", dat_o, 32'hDE22BE44);

      // Master abandons a write while it is in ISSUE
      xfer(1'b1, BASE + 32'h20, 32'hCAFEF00D, 4'hF, 1);
      check("drop_ack_cnt", ack_cnt, 0);
      check("drop_csb_lo", csb_lo, 1);
      ref_mem[8] = 32'hCAFEF00D;
      run(1'b0, BASE + 32'h20, 32'h0, 4'hF);
      check("rd_after_drop", dat_o, 32'hCAFEF00D);

      // Reset lands while a read is waiting on the SRAM
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
      @(posedge clk); #1;
      check("rstw_issue_csb", {31'b0, csb}, 0);
      @(posedge clk); #1;
      check("rstw_wait_ack", {31'b0, ack_o}, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("rstw");
      rst = 1'b0; cyc = 1'b0; stb = 1'b0;
      ref_dat = '0;
      @(posedge clk); #1;
      check("rstw_no_late_ack", {31'b0, ack_o}, 0);
      run(1'b0, BASE + 32'h10, 32'h0, 4'hF);
      check("rd_after_rst", dat_o, 32'hDE22BE44);

      // One word beyond the window
      run(1'b0, 32'h3000_0400, 32'h0, 4'hF);
`ifndef WB_SRAM_ERR_EN
      check("alias_word0", dat_o, ref_mem[0]);
`endif

      for (int n = 0; n < 60; n++) begin
         logic [31:0] ra;
         case ($urandom_range(0, 3))
            0:       ra = $urandom;
            1:       ra = BASE + 32'h400 + ($urandom_range(0, 4095));
            default: ra = BASE + $urandom_range(0, 4 * WORDS - 1);
         endcase
         run(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
